pc_fetch_unit: RTL and testbench

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

---
 rtl/pc_fetch_unit.sv | 150 +++++++++++++++
 tb/tb_pc_fetch_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Program-counter fetch unit: IDLE/FETCH/HOLD sequencer issuing instruction-memory requests.
// Define PC_EXCEPTION_EN to trap misaligned redirect targets to EXC_VECTOR and add exc_out.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        start_in,
    input  logic        stall_in,
    input  logic        branch_in,
    input  logic [31:0] branch_target_in,
    input  logic        jump_in,
    input  logic [31:0] jump_target_in,
    output logic        imem_req_out,
    output logic [31:0] imem_addr_out,
    input  logic        imem_ack_in,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4_out,
    output logic        inst_valid_out
`ifdef PC_EXCEPTION_EN
    ,
    output logic        exc_out
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_target_q, pend_target_d;
    logic        req_q;
    logic        inst_valid_q, inst_valid_d;
    logic        exc_q, exc_d;

    logic        live_redir;
    logic [31:0] live_target;
    logic        apply_target;
    logic [31:0] raw_target;
    logic [31:0] pc_plus4;

    assign pc_plus4    = pc_q + 32'd4;
    assign live_redir  = jump_in | branch_in;
    assign live_target = jump_in ? jump_target_in : branch_target_in;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        inst_valid_d  = 1'b0;
        exc_d         = 1'b0;
        apply_target  = 1'b0;
        raw_target    = 32'h0;

        case (state_q)
            ST_IDLE: begin
                if (start_in) begin
                    state_d = ST_FETCH;
                    pc_d    = RESET_VECTOR;
                end
            end
            ST_FETCH: begin
                if (imem_ack_in) begin
                    inst_valid_d = 1'b1;
                    pend_valid_d = 1'b0;
                    if (live_redir) begin
                        apply_target = 1'b1;
                        raw_target   = live_target;
                    end else if (pend_valid_q) begin
                        apply_target = 1'b1;
                        raw_target   = pend_target_q;
                    end else begin
                        pc_d = pc_plus4;
                    end
                    state_d = stall_in ? ST_HOLD : ST_FETCH;
                end else if (live_redir) begin
                    // Address must stay stable until ack, so the redirect waits here.
                    pend_valid_d  = 1'b1;
                    pend_target_d = live_target;
                end
            end
            ST_HOLD: begin
                if (live_redir) begin
                    apply_target = 1'b1;
                    raw_target   = live_target;
                end
                if (!stall_in) begin
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (apply_target) begin
`ifdef PC_EXCEPTION_EN
            if (raw_target[1:0] != 2'b00) begin
                pc_d  = EXC_VECTOR;
                exc_d = 1'b1;
            end else begin
                pc_d = raw_target;
            end
`else
            pc_d = {raw_target[31:2], 2'b00};
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_VECTOR;
            pend_valid_q  <= 1'b0;
            pend_target_q <= 32'h0;
            req_q         <= 1'b0;
            inst_valid_q  <= 1'b0;
            exc_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
            req_q         <= (state_d == ST_FETCH);
            inst_valid_q  <= inst_valid_d;
            exc_q         <= exc_d;
        end
    end

    assign imem_req_out   = req_q;
    assign imem_addr_out  = pc_q;
    assign pc_out         = pc_q;
    assign pc_plus4_out   = pc_plus4;
    assign inst_valid_out = inst_valid_q;

`ifdef PC_EXCEPTION_EN
    assign exc_out = exc_q;
`else
    // Trap path is compiled out; these bits intentionally have no consumer.
    logic unused_trap_bits;
    assign unused_trap_bits = ^{EXC_VECTOR, raw_target[1:0], exc_q};
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit (default parameters).
// Builds with or without PC_EXCEPTION_EN; the misaligned-jump expectation follows the macro.
module tb_pc_fetch_unit;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        start_in;
    logic        stall_in;
    logic        branch_in;
    logic [31:0] branch_target_in;
    logic        jump_in;
    logic [31:0] jump_target_in;
    logic        imem_req_out;
    logic [31:0] imem_addr_out;
    logic        imem_ack_in;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4_out;
    logic        inst_valid_out;
`ifdef PC_EXCEPTION_EN
    logic        exc_out;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk_in = ~clk_in;

    pc_fetch_unit dut (
        .clk_in           (clk_in),
        .rst_n_in         (rst_n_in),
        .start_in         (start_in),
        .stall_in         (stall_in),
        .branch_in        (branch_in),
        .branch_target_in (branch_target_in),
        .jump_in          (jump_in),
        .jump_target_in   (jump_target_in),
        .imem_req_out     (imem_req_out),
        .imem_addr_out    (imem_addr_out),
        .imem_ack_in      (imem_ack_in),
        .pc_out           (pc_out),
        .pc_plus4_out     (pc_plus4_out),
        .inst_valid_out   (inst_valid_out)
`ifdef PC_EXCEPTION_EN
        ,
        .exc_out          (exc_out)
`endif
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic clear_redirects();
        branch_in        = 1'b0;
        jump_in          = 1'b0;
        branch_target_in = 32'h0;
        jump_target_in   = 32'h0;
    endtask

    initial begin
        logic [31:0] pc_after_misaligned;
`ifdef PC_EXCEPTION_EN
        pc_after_misaligned = 32'h0000_0080;
`else
        pc_after_misaligned = 32'h0000_0100;
`endif
        rst_n_in    = 1'b0;
        start_in    = 1'b0;
        stall_in    = 1'b0;
        imem_ack_in = 1'b0;
        clear_redirects();
        #1;
        check("reset_req",   {31'h0, imem_req_out},   32'h0);
        check("reset_pc",    pc_out,                  32'h0);
        check("reset_valid", {31'h0, inst_valid_out}, 32'h0);
        step();
        step();
        rst_n_in = 1'b1;

        // IDLE ignores ack and stays quiet without start
        imem_ack_in = 1'b1;
        step();
        check("idle_req",       {31'h0, imem_req_out},   32'h0);
        check("idle_ack_valid", {31'h0, inst_valid_out}, 32'h0);
        imem_ack_in = 1'b0;

        start_in = 1'b1;
        step();
        start_in = 1'b0;
        check("start_req",  {31'h0, imem_req_out}, 32'h1);
        check("start_addr", imem_addr_out,         32'h0);

        // back-to-back acks: 0x0, 0x4, 0x8
        imem_ack_in = 1'b1;
        step();
        check("seq_addr4",  imem_addr_out,           32'h4);
        check("seq_valid4", {31'h0, inst_valid_out}, 32'h1);
        step();
        check("seq_addr8",  imem_addr_out,           32'h8);
        check("seq_valid8", {31'h0, inst_valid_out}, 32'h1);
        imem_ack_in = 1'b0;
        step();
        check("valid_single", {31'h0, inst_valid_out}, 32'h0);
        step();
        check("wait_req",  {31'h0, imem_req_out}, 32'h1);
        check("wait_addr", imem_addr_out,         32'h8);

        // jump to 0x100 at ack
        jump_in = 1'b1; jump_target_in = 32'h100; imem_ack_in = 1'b1;
        step();
        clear_redirects(); imem_ack_in = 1'b0;
        check("jump_pc", pc_out, 32'h100);

        // branch two cycles before ack is held pending
        branch_in = 1'b1; branch_target_in = 32'h200;
        step();
        clear_redirects();
        check("pend_addr_stable", imem_addr_out,         32'h100);
        check("pend_req_stable",  {31'h0, imem_req_out}, 32'h1);
        step();
        imem_ack_in = 1'b1;
        step();
        check("pend_pc",     pc_out,       32'h200);
        check("pend_plus4",  pc_plus4_out, 32'h204);
        step();
        imem_ack_in = 1'b0;
        check("pend_cleared", pc_out, 32'h204);

        // same-cycle jump beats branch
        jump_in = 1'b1; jump_target_in = 32'h300;
        branch_in = 1'b1; branch_target_in = 32'h200; imem_ack_in = 1'b1;
        step();
        clear_redirects(); imem_ack_in = 1'b0;
        check("jump_over_branch", pc_out, 32'h300);

        // later pending redirect overwrites the earlier one
        branch_in = 1'b1; branch_target_in = 32'h400;
        step();
        clear_redirects();
        jump_in = 1'b1; jump_target_in = 32'h500;
        step();
        clear_redirects(); imem_ack_in = 1'b1;
        step();
        imem_ack_in = 1'b0;
        check("pend_overwrite", pc_out, 32'h500);

        // stall without ack keeps the request; stall at ack enters HOLD
        stall_in = 1'b1;
        step();
        check("stall_req_kept", {31'h0, imem_req_out}, 32'h1);
        imem_ack_in = 1'b1;
        step();
        imem_ack_in = 1'b0;
        check("stall_ack_pc",    pc_out,                  32'h504);
        check("stall_ack_valid", {31'h0, inst_valid_out}, 32'h1);
        check("hold_req",        {31'h0, imem_req_out},   32'h0);
        imem_ack_in = 1'b1;
        step();
        imem_ack_in = 1'b0;
        check("hold_ack_ignored_pc",    pc_out,                  32'h504);
        check("hold_ack_ignored_valid", {31'h0, inst_valid_out}, 32'h0);

        // redirect in HOLD loads PC directly
        branch_in = 1'b1; branch_target_in = 32'h600;
        step();
        clear_redirects();
        check("hold_branch_pc", pc_out,                32'h600);
        check("hold_branch_req", {31'h0, imem_req_out}, 32'h0);
        stall_in = 1'b0;
        step();
        check("resume_req",  {31'h0, imem_req_out}, 32'h1);
        check("resume_addr", imem_addr_out,         32'h600);

        // wrap at top of address space
        jump_in = 1'b1; jump_target_in = 32'hFFFF_FFFC; imem_ack_in = 1'b1;
        step();
        clear_redirects();
        check("wrap_plus4", pc_plus4_out, 32'h0);
        step();
        check("wrap_pc", pc_out, 32'h0);

        // misaligned jump target
        jump_in = 1'b1; jump_target_in = 32'h0000_0102;
        step();
        clear_redirects(); imem_ack_in = 1'b0;
        check("misaligned_pc", pc_out, pc_after_misaligned);
`ifdef PC_EXCEPTION_EN
        check("exc_pulse", {31'h0, exc_out}, 32'h1);
        step();
        check("exc_single", {31'h0, exc_out}, 32'h0);
`endif

        // stall at ack, then reset while in HOLD
        stall_in = 1'b1; imem_ack_in = 1'b1;
        step();
        stall_in = 1'b0; imem_ack_in = 1'b0;
        check("pre_reset_hold_req", {31'h0, imem_req_out}, 32'h0);
        rst_n_in = 1'b0;
        #1;
        check("hold_reset_pc",  pc_out,                32'h0);
        check("hold_reset_req", {31'h0, imem_req_out}, 32'h0);
        step();
        rst_n_in = 1'b1;
        step();
        check("post_reset_idle", {31'h0, imem_req_out}, 32'h0);

        // reset mid-fetch abandons the request
        start_in = 1'b1;
        step();
        start_in = 1'b0;
        check("refetch_req", {31'h0, imem_req_out}, 32'h1);
        rst_n_in = 1'b0;
        #1;
        check("midfetch_reset_req", {31'h0, imem_req_out}, 32'h0);
        imem_ack_in = 1'b1;
        step();
        check("midfetch_no_valid", {31'h0, inst_valid_out}, 32'h0);
        rst_n_in = 1'b1;
        step();
        imem_ack_in = 1'b0;
        check("midfetch_after_req",   {31'h0, imem_req_out},   32'h0);
        check("midfetch_after_valid", {31'h0, inst_valid_out}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
